// File: rtl/fifo_word_reader.sv
// Purpose : drains bytes from the 8-bit sync FIFO read port and packs them little-endian
//           into 32-bit words; partial words leave on flush or after an idle timeout.
// Latency : byte lands one cycle after its read is accepted; out_valid rises the cycle
//           after the word completes. Backpressure: while out_valid is high the word is
//           held stable and no FIFO reads are issued until out_ready completes the handshake.
// Ports   : clock/reset (async, active-low); fifo_empty, fifo_wr_active, fifo_data in and
//           fifo_rn out toward the FIFO; flush in; out_data/out_bytes/out_valid out with
//           out_ready in toward the consumer; words_sent handshake counter; busy status.
module fifo_word_reader #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic             fifo_wr_active,
    output logic             fifo_rn,
    input  logic [7:0]       fifo_data,
    input  logic             flush,
    output logic [31:0]      out_data,
    output logic [2:0]       out_bytes,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] words_sent,
    output logic             busy
);
    localparam int                IDLE_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

    typedef enum logic {
        S_FILL    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [2:0]        r_count;       // bytes captured into the current word, 0..4
    logic              r_inflight;    // a read was accepted last cycle; fifo_data is valid now
    logic              r_flush_pend;
    logic [IDLE_W-1:0] r_idle;
    logic [31:0]       r_lanes;
    logic [2:0]        r_out_bytes;
    logic [CNT_W-1:0]  r_words;

    logic              w_fill;
    logic [2:0]        w_occ;
    logic              w_acc;
    logic              w_cap;
    logic              w_full;
    logic              w_drain_ok;
    logic              w_flush_go;
    logic              w_timeout_go;
    logic              w_enter;
    logic              w_hs;

    // ---------------------------------------------------------------
    // Read request / pipeline control
    // ---------------------------------------------------------------
    always_comb begin
        w_fill     = (r_state == S_FILL);
        // Reserve a lane for the byte still in flight so a word never overfills.
        w_occ      = r_count + {2'b00, r_inflight};
        fifo_rn    = reset && w_fill && !fifo_empty && !fifo_wr_active
                     && !r_flush_pend && (w_occ < 3'd4);
        w_acc      = fifo_rn;
        w_cap      = r_inflight;
        w_full     = w_cap && (r_count == 3'd3);
        w_drain_ok = !r_inflight && (r_count != 3'd0);
        w_flush_go = r_flush_pend && w_drain_ok;
        // A read accepted on the very cycle the timer expires would land after the
        // word left; let that read win and keep filling instead.
        w_timeout_go = (TIMEOUT != 0) && (r_idle == IDLE_MAX) && w_drain_ok && !w_acc;
        w_enter    = w_fill && (w_full || w_flush_go || w_timeout_go);
        w_hs       = (r_state == S_PRESENT) && out_ready;
    end

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL:    if (w_enter)   w_state_nxt = S_PRESENT;
            S_PRESENT: if (out_ready) w_state_nxt = S_FILL;
            default:                  w_state_nxt = S_FILL;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        out_valid  = (r_state == S_PRESENT);
        out_data   = r_lanes;
        out_bytes  = r_out_bytes;
        words_sent = r_words;
        busy       = (r_count != 3'd0) || r_inflight || (r_state == S_PRESENT);
    end

    // ---------------------------------------------------------------
    // Datapath: lanes, counters, flush and idle tracking
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count      <= 3'd0;
            r_inflight   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_idle       <= '0;
            r_lanes      <= 32'h0;
            r_out_bytes  <= 3'd0;
            r_words      <= '0;
        end else begin
            r_inflight <= w_acc;

            if (w_hs) begin
                r_lanes     <= 32'h0;
                r_count     <= 3'd0;
                r_out_bytes <= 3'd0;
                r_words     <= r_words + 1'b1;
            end else if (w_cap) begin
                r_lanes[{r_count[1:0], 3'b000} +: 8] <= fifo_data;
                r_count <= r_count + 3'd1;
            end

            // A full word enters with the capture of its 4th byte; partial words
            // enter with no capture pending, so r_count is already final.
            if (w_enter) begin
                r_out_bytes <= w_cap ? 3'd4 : r_count;
            end

            if (w_enter || w_hs) begin
                r_flush_pend <= 1'b0;
            end else if (w_fill && flush) begin
                r_flush_pend <= 1'b1;
            end else if (r_flush_pend && !r_inflight && (r_count == 3'd0)) begin
                // Nothing to push out: the flush request simply lapses.
                r_flush_pend <= 1'b0;
            end

            if (!w_fill || w_acc || w_cap || w_enter) begin
                r_idle <= '0;
            end else if ((r_count != 3'd0) && (r_idle != IDLE_MAX)) begin
                r_idle <= r_idle + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_word_reader.sv
module tb_fifo_word_reader;
    logic        clock;
    logic        reset;
    logic        fifo_empty;
    logic        fifo_wr_active;
    logic        fifo_rn;
    logic [7:0]  fifo_data;
    logic        flush;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  words_sent;
    logic        busy;

    int tests_run;
    int tests_failed;

    logic [7:0] fifo_q[$];
    logic [7:0] pend_q[$];

    fifo_word_reader #(.TIMEOUT(16), .CNT_W(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .fifo_empty     (fifo_empty),
        .fifo_wr_active (fifo_wr_active),
        .fifo_rn        (fifo_rn),
        .fifo_data      (fifo_data),
        .flush          (flush),
        .out_data       (out_data),
        .out_bytes      (out_bytes),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .words_sent     (words_sent),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural FIFO: registered read data, empty flag updated at the clock edge,
    // bytes loaded by tests become visible after the next edge.
    always @(posedge clock) begin
        if (!reset) begin
            fifo_q.delete();
            fifo_empty <= 1'b1;
            fifo_data  <= 8'h00;
        end else begin
            if (fifo_rn && !fifo_empty && !fifo_wr_active && fifo_q.size() > 0)
                fifo_data <= fifo_q.pop_front();
            while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    task automatic push_byte(input logic [7:0] b);
        pend_q.push_back(b);
    endtask

    task automatic load_seq(input logic [7:0] first, input int n, input logic [7:0] step);
        logic [7:0] v;
        v = first;
        for (int i = 0; i < n; i++) begin
            pend_q.push_back(v);
            v = v + step;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0; fifo_wr_active = 1'b0;
        pend_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_valid(input int limit, output int cycles, output bit ok);
        ok = 1'b0; cycles = 0;
        while (!ok && cycles < limit) begin
            @(negedge clock); #1;
            cycles++;
            if (out_valid) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0; fifo_wr_active = 1'b0;
        @(negedge clock); #1;
        tests_run++; if (out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_out_data got=%h want=%h", out_data, 32'h0); end
        tests_run++; if (out_bytes !== 3'd0) begin tests_failed++; $display("FAIL reset_out_bytes got=%0d want=0", out_bytes); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        tests_run++; if (words_sent !== 2'd0) begin tests_failed++; $display("FAIL reset_words_sent got=%0d want=0", words_sent); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b want=0", busy); end
        tests_run++; if (fifo_rn !== 1'b0) begin tests_failed++; $display("FAIL reset_fifo_rn got=%b want=0", fifo_rn); end
        reset = 1'b1;
    endtask

    task automatic test_full_word();
        int rn_tot, rn_run, rn_max;
        bit ok;
        do_reset();
        out_ready = 1'b1;
        load_seq(8'h11, 4, 8'h11);
        rn_tot = 0; rn_run = 0; rn_max = 0; ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock); #1;
            if (fifo_rn) begin
                rn_tot++; rn_run++;
                if (rn_run > rn_max) rn_max = rn_run;
            end else rn_run = 0;
            if (out_valid) ok = 1'b1;
        end
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL full_word_timeout out_valid never rose"); end
        tests_run++; if (rn_tot != 4 || rn_max != 4) begin tests_failed++; $display("FAIL full_word_rn total=%0d run=%0d want 4/4", rn_tot, rn_max); end
        tests_run++; if (out_data !== 32'h44332211) begin tests_failed++; $display("FAIL full_word_data got=%h want=44332211", out_data); end
        tests_run++; if (out_bytes !== 3'd4) begin tests_failed++; $display("FAIL full_word_bytes got=%0d want=4", out_bytes); end
        @(negedge clock); #1;
        tests_run++; if (out_valid !== 1'b0 || words_sent !== 2'd1 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL full_word_after_hs valid=%b words=%0d busy=%b want 0/1/0", out_valid, words_sent, busy);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit ok;
        do_reset();
        out_ready = 1'b0;
        load_seq(8'h01, 8, 8'h01);
        wait_valid(30, cyc, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL bp_first_timeout out_valid never rose"); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock); #1;
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 32'h04030201 || out_bytes !== 3'd4 || fifo_rn !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold cycle=%0d valid=%b data=%h bytes=%0d rn=%b want 1/04030201/4/0", i, out_valid, out_data, out_bytes, fifo_rn);
            end
        end
        out_ready = 1'b1;
        @(negedge clock); #1;
        tests_run++; if (out_valid !== 1'b0 || words_sent !== 2'd1) begin tests_failed++; $display("FAIL bp_first_hs valid=%b words=%0d want 0/1", out_valid, words_sent); end
        wait_valid(30, cyc, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL bp_second_timeout out_valid never rose"); end
        tests_run++; if (out_data !== 32'h08070605 || out_bytes !== 3'd4) begin tests_failed++; $display("FAIL bp_second_word data=%h bytes=%0d want 08070605/4", out_data, out_bytes); end
        @(negedge clock); #1;
        tests_run++; if (words_sent !== 2'd2) begin tests_failed++; $display("FAIL bp_words got=%0d want=2", words_sent); end
    endtask

    task automatic test_timeout();
        int last_rn, vk;
        bit ok;
        do_reset();
        out_ready = 1'b0;
        load_seq(8'hAA, 3, 8'h11);
        last_rn = -1; vk = -1; ok = 1'b0;
        for (int k = 1; k <= 40 && !ok; k++) begin
            @(negedge clock); #1;
            if (fifo_rn) last_rn = k;
            if (out_valid) begin ok = 1'b1; vk = k; end
        end
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL timeout_never out_valid never rose"); end
        // Last read requested 1 cycle before its accept, captured 1 cycle later,
        // then 17 cycles to out_valid: 19 sample points apart.
        tests_run++; if (vk - last_rn != 19) begin tests_failed++; $display("FAIL timeout_delay got=%0d want=19", vk - last_rn); end
        tests_run++; if (out_data !== 32'h00CCBBAA || out_bytes !== 3'd3) begin tests_failed++; $display("FAIL timeout_word data=%h bytes=%0d want 00CCBBAA/3", out_data, out_bytes); end
        out_ready = 1'b1;
        @(negedge clock); #1;
        tests_run++; if (words_sent !== 2'd1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL timeout_hs words=%0d valid=%b want 1/0", words_sent, out_valid); end
    endtask

    task automatic test_flush_inflight();
        int extra;
        bit ok;
        do_reset();
        out_ready = 1'b1;
        push_byte(8'h10);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clock); #1;
            if (fifo_rn) ok = 1'b1;
        end
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL flush_setup_timeout first read never requested"); end
        @(negedge clock);
        push_byte(8'h5A); push_byte(8'h77); push_byte(8'h88);
        @(negedge clock);
        flush = 1'b1; #1;
        tests_run++; if (fifo_rn !== 1'b1) begin tests_failed++; $display("FAIL flush_read_same_cycle rn=%b want=1", fifo_rn); end
        @(negedge clock);
        flush = 1'b0; #1;
        extra = 0; ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (out_valid) ok = 1'b1;
            else begin
                if (fifo_rn) extra++;
                @(negedge clock); #1;
            end
        end
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL flush_timeout out_valid never rose"); end
        tests_run++; if (extra != 0) begin tests_failed++; $display("FAIL flush_blocks_reads extra_reads=%0d want=0", extra); end
        tests_run++; if (out_data !== 32'h00005A10 || out_bytes !== 3'd2) begin tests_failed++; $display("FAIL flush_word data=%h bytes=%0d want 00005A10/2", out_data, out_bytes); end
        @(negedge clock); #1;
        tests_run++; if (out_valid !== 1'b0 || fifo_rn !== 1'b1) begin tests_failed++; $display("FAIL flush_resume valid=%b rn=%b want 0/1", out_valid, fifo_rn); end
    endtask

    task automatic test_write_priority();
        int cyc;
        bit ok;
        do_reset();
        out_ready = 1'b1;
        fifo_wr_active = 1'b1;
        load_seq(8'hA1, 4, 8'h01);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock); #1;
            tests_run++; if (fifo_rn !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL wr_priority cycle=%0d rn=%b busy=%b want 0/0", i, fifo_rn, busy); end
        end
        fifo_wr_active = 1'b0;
        wait_valid(20, cyc, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL wr_priority_timeout out_valid never rose"); end
        tests_run++; if (out_data !== 32'hA4A3A2A1 || out_bytes !== 3'd4) begin tests_failed++; $display("FAIL wr_priority_word data=%h bytes=%0d want A4A3A2A1/4", out_data, out_bytes); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit ok;
        do_reset();
        out_ready = 1'b1;
        load_seq(8'h11, 4, 8'h11);
        wait_valid(20, cyc, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rst_mid_setup_timeout out_valid never rose"); end
        @(negedge clock); #1;
        tests_run++; if (words_sent !== 2'd1) begin tests_failed++; $display("FAIL rst_mid_words_before got=%0d want=1", words_sent); end
        push_byte(8'hD1); push_byte(8'hD2);
        repeat (3) @(negedge clock);
        push_byte(8'hE1);
        @(negedge clock); #1;
        tests_run++; if (busy !== 1'b1 || fifo_rn !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_precond busy=%b rn=%b want 1/1", busy, fifo_rn); end
        reset = 1'b0; #1;
        tests_run++; if (out_data !== 32'h0 || out_bytes !== 3'd0 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_outputs data=%h bytes=%0d valid=%b want 0/0/0", out_data, out_bytes, out_valid);
        end
        tests_run++; if (words_sent !== 2'd0 || busy !== 1'b0 || fifo_rn !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_status words=%0d busy=%b rn=%b want 0/0/0", words_sent, busy, fifo_rn);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_wrap();
        int hs;
        logic [31:0] last_data;
        do_reset();
        out_ready = 1'b1;
        load_seq(8'h30, 20, 8'h01);
        hs = 0; last_data = 32'h0;
        for (int i = 0; i < 200 && hs < 5; i++) begin
            @(negedge clock); #1;
            if (out_valid && out_ready) begin
                if (hs == 4) begin
                    tests_run++; if (words_sent !== 2'd0) begin tests_failed++; $display("FAIL wrap_at_four got=%0d want=0", words_sent); end
                    last_data = out_data;
                end
                hs++;
            end
        end
        @(negedge clock); #1;
        tests_run++; if (hs != 5) begin tests_failed++; $display("FAIL wrap_timeout handshakes=%0d want=5", hs); end
        tests_run++; if (words_sent !== 2'd1) begin tests_failed++; $display("FAIL wrap_words got=%0d want=1", words_sent); end
        tests_run++; if (last_data !== 32'h43424140) begin tests_failed++; $display("FAIL wrap_last_word got=%h want=43424140", last_data); end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0; fifo_wr_active = 1'b0;
        test_reset();
        test_full_word();
        test_backpressure();
        test_timeout();
        test_flush_inflight();
        test_write_priority();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fifo_word_reader.md
Name: fifo_word_reader

Overview:
- Read-side companion to the team's 8-bit synchronous FIFO.
- Drains bytes through the FIFO read port (rn, empty, registered byte output) and packs them little-endian into 32-bit words.
- Presents each word to a downstream consumer over a valid/ready handshake.
- Emits partial words on an explicit flush, or after an idle timeout, so trailing bytes never stall in the packer.

Parameters:
- TIMEOUT, 16: idle cycles with a partial word held before it is emitted; 0 disables the timeout.
- CNT_W, 16: width of the words_sent counter.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_wr_active  input  1  FIFO write strobe this cycle. The FIFO gives writes priority, so a read is not accepted while this is high.
- fifo_rn  output  1  FIFO read request; combinational.
- fifo_data  input  8  FIFO registered read data, valid the cycle after an accepted read.
- flush  input  1  force out the current partial word.
- out_data  output  32  packed word; byte 0 in [7:0].
- out_bytes  output  3  valid bytes in out_data, range 1..4.
- out_valid  output  1  word available.
- out_ready  input  1  consumer accepts the word.
- words_sent  output  CNT_W  count of completed out handshakes; wraps.
- busy  output  1  high when count>0, inflight=1, or out_valid=1.

Behaviour:
- Asynchronous reset (reset=0) forces all of the following immediately:
  - out_data=0, out_bytes=0, out_valid=0, words_sent=0, busy=0;
  - internal count=0, inflight=0, idle counter=0, flush_pend=0.
  - fifo_rn is 0 while reset is low.
- Read acceptance: a read is accepted in a cycle where fifo_rn=1, fifo_empty=0 and fifo_wr_active=0.
- Read request: fifo_rn = !out_valid && !fifo_empty && !fifo_wr_active && !flush_pend && (count+inflight < 4).
- Read pipeline:
  - An accepted read sets inflight=1 for the next cycle.
  - In that cycle, fifo_data is written into byte lane [count], count increments, and inflight clears unless another read was accepted.
  - Back-to-back reads are allowed, giving 1 byte/cycle sustained.
- States:
  - FILL: out_valid=0, collecting bytes.
  - PRESENT: out_valid=1, holding the word.
- FILL -> PRESENT occurs on any of:
  - (a) count reaches 4 after a capture; out_bytes=4.
  - (b) flush_pend=1, inflight=0 and count>0; out_bytes=count.
  - (c) TIMEOUT≠0, the idle counter reaches TIMEOUT, and count>0, inflight=0; out_bytes=count.
  - out_valid rises the cycle after the condition is met.
  - Unused lanes of a partial word are 0.
- flush:
  - Sampled while in FILL; sets flush_pend.
  - flush_pend blocks new reads and waits for any in-flight byte to land.
  - If count=0 and inflight=0, flush is a no-op and flush_pend clears.
  - flush while in PRESENT is ignored.
- Idle counter:
  - Increments each FILL cycle with count>0, inflight=0 and no accepted read.
  - Clears on any accepted read, capture, or entry to PRESENT.
  - Saturates at TIMEOUT.
- PRESENT:
  - out_data and out_bytes are stable and no reads are issued.
  - On out_valid && out_ready: out_valid=0 next cycle, count=0, lanes cleared, words_sent+1 (wraps to 0 at 2^CNT_W), return to FILL.
  - Minimum inter-word gap is 1 cycle.
- out_valid, once high, stays high until the handshake completes; it is never withdrawn.
- Reset mid-operation:
  - Any in-flight byte and any partial word are discarded.
  - The FIFO pointer has already advanced, so these bytes are lost; the system reset must cover both blocks.
- fifo_data is ignored in cycles with inflight=0.

Test Plan:
- Full word, sink always ready:
  - Stimulus: FIFO holds 0x11,0x22,0x33,0x44; out_ready=1.
  - Required: fifo_rn high 4 consecutive cycles; out_valid=1 with out_data=0x44332211, out_bytes=4; words_sent=1.
- Backpressure:
  - Stimulus: 8 bytes 0x01..0x08; out_ready=0 for 10 cycles, then 1.
  - Required: first word 0x04030201 held stable; fifo_rn=0 throughout the hold; second word 0x08070605 follows; words_sent=2.
- Timeout partial:
  - Stimulus: TIMEOUT=16; 3 bytes 0xAA,0xBB,0xCC, then FIFO stays empty.
  - Required: out_valid rises 17 cycles after the last capture with out_data=0x00CCBBAA, out_bytes=3.
- Flush with an in-flight read:
  - Stimulus: flush asserted in the same cycle a read of 0x5A is accepted (count=1).
  - Required: no further reads are issued; next word has out_bytes=2 and 0x5A in [15:8].
- Write priority:
  - Stimulus: fifo_wr_active=1 while not empty.
  - Required: fifo_rn=0; no byte is captured.
- Reset mid-word and wrap:
  - Stimulus: drop reset while count=2.
  - Required: all outputs are 0 immediately.
  - Separately, with CNT_W=2, 5 completed words give words_sent=1.
